// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a 32-cycle restoring divider for MIPS DIV/DIVU, plus direct HI/LO writes.
// Latency 33 cycles from accepted start to done (1 cycle on divide-by-zero); busy stalls the pipeline, flush aborts.
module hilo_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_d;
  logic [5:0]  cnt;
  logic [31:0] dvd;       // dividend shifts out MSB-first while quotient bits shift in
  logic [31:0] dvs;
  logic [32:0] rem;
  logic        qneg, rneg;

  logic        start_ok;
  logic        div_zero;
  logic [31:0] a_mag, b_mag;
  logic [33:0] rem_sh, diff;
  logic [32:0] rem_nxt;
  logic [31:0] q_nxt;

  assign start_ok = (state != RUN) && div_start && !flush;
  assign div_zero = (src2 == 32'd0);
  assign a_mag    = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
  assign b_mag    = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;

  assign rem_sh  = {rem, dvd[31]};
  assign diff    = rem_sh - {2'b00, dvs};
  assign rem_nxt = diff[33] ? rem_sh[32:0] : diff[32:0];
  assign q_nxt   = {dvd[30:0], ~diff[33]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_d = div_zero ? DONE : RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (flush)              state_d = IDLE;
        else if (cnt == 6'd31)  state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 6'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      dvd  <= 32'd0;
      dvs  <= 32'd0;
      rem  <= 33'd0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else if (state != RUN) begin
      if (hi_we) hi <= hi_wdata;
      if (lo_we) lo <= lo_wdata;
      // a divide issued together with a direct write wins for the result it produces
      if (start_ok) begin
        if (div_zero) begin
          hi <= 32'd0;
          lo <= 32'd0;
        end else begin
          dvd  <= a_mag;
          dvs  <= b_mag;
          rem  <= 33'd0;
          cnt  <= 6'd0;
          qneg <= div_signed && (src1[31] ^ src2[31]);
          rneg <= div_signed && src1[31];
        end
      end
    end else if (!flush) begin
      dvd <= q_nxt;
      rem <= rem_nxt;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) begin
        lo <= qneg ? (~q_nxt + 32'd1) : q_nxt;
        hi <= rneg ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
      end
    end
  end

endmodule

// File: doc/hilo_div_unit.md
HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- div_start, 1 bit: request a divide this cycle.
- div_signed, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU).
- src1, 32 bits: dividend (rs).
- src2, 32 bits: divisor (rt).
- hi_we, 1 bit: direct write of HI (MTHI or MULT/MULTU high word).
- lo_we, 1 bit: direct write of LO.
- hi_wdata, 32 bits: data for HI.
- lo_wdata, 32 bits: data for LO.
- flush, 1 bit: abort any divide in progress.
REQ-003 The block SHALL have these outputs:
- busy, 1 bit: divide iterating; the pipeline stalls while busy is high.
- done, 1 bit: one-cycle pulse marking the first cycle the divide result is visible on hi/lo.
- hi, 32 bits: HI register.
- lo, 32 bits: LO register.

Function
REQ-004 State machine SHALL have three states:
- IDLE
- RUN
- DONE
REQ-005 div_start SHALL be sampled only in IDLE or DONE; in RUN it SHALL be ignored.
REQ-006 Accepted div_start with flush=0 and src2!=0 SHALL, at that edge:
- latch |src1| into the working dividend and |src2| into the divisor (magnitudes only when div_signed=1, else raw values);
- latch sign flags: quotient negative = src1[31]^src2[31], remainder negative = src1[31], both only when div_signed=1;
- clear the 6-bit iteration counter;
- enter RUN.
REQ-007 RUN SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder, producing one quotient bit MSB-first, for exactly 32 cycles (counter 0..31).
REQ-008 At the edge ending RUN cycle 31, the block SHALL:
- write LO = quotient, negated (two's complement) if the quotient-negative flag is set;
- write HI = remainder, negated if the remainder-negative flag is set;
- enter DONE.
REQ-009 DONE SHALL last one cycle with done=1, then return to IDLE, or to RUN if a new div_start is accepted in that cycle.
REQ-010 Latency: div_start sampled in cycle T, busy=1 in cycles T+1..T+32, done=1 and new hi/lo visible in cycle T+33.
REQ-011 Divide by zero (accepted div_start with src2==0, signed or unsigned) SHALL skip RUN, write HI=0 and LO=0 at that edge, and enter DONE, so done=1 in cycle T+1.
REQ-012 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000, with no exception or flag.
REQ-013 busy SHALL equal (state==RUN) and be driven from registered state only; done SHALL equal (state==DONE).
REQ-014 hi_we and lo_we SHALL write hi_wdata and lo_wdata at the edge when the state is IDLE or DONE, and SHALL be ignored in RUN.
REQ-015 If hi_we or lo_we coincides with an accepted div_start, the direct write SHALL take effect at that edge, and the divide result SHALL overwrite it on completion.
REQ-016 flush=1 in RUN or DONE SHALL return to IDLE at the next edge, leave hi/lo unchanged, and suppress done.
REQ-017 flush in the last RUN cycle SHALL suppress the REQ-008 write.
REQ-018 flush together with div_start SHALL cause div_start to be ignored.
REQ-019 All working registers SHALL be internal; hi and lo SHALL change only per REQ-008, REQ-011, REQ-014 and REQ-020.

Reset
REQ-020 rst=1 at a rising edge SHALL set:
- state = IDLE;
- counter = 0;
- hi = 0 and lo = 0;
- busy = 0 and done = 0.
REQ-021 Reset SHALL override div_start, hi_we, lo_we and flush in the same cycle, and SHALL abort a divide mid-RUN with no hi/lo write.

Verification
REQ-022 Unsigned: src1=100, src2=7, div_signed=0, start at T -> busy T+1..T+32, done at T+33, LO=14, HI=2.
REQ-023 Signed: src1=0xFFFFFFF9 (-7), src2=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); src1=0x80000000, src2=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 Divide by zero: hi=lo=0x12345678 preloaded, src1=5, src2=0 -> done at T+1, busy never 1, HI=LO=0.
REQ-025 Flush: preload HI=0xAAAA0000, LO=0x0000BBBB, start divide, flush at T+20 -> IDLE at T+21, no done pulse, hi/lo keep preloaded values; repeat with flush at T+32, same result.
REQ-026 Direct writes: hi_we=1 with hi_wdata=0xDEADBEEF during RUN -> hi unchanged and the divide result lands at T+33; the same write in IDLE -> hi=0xDEADBEEF next cycle.
REQ-027 Back-to-back and reset: div_start in the DONE cycle -> second divide done 33 cycles later; rst at T+10 -> IDLE, hi=lo=0, no done.
